// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1011 sequence-detector slice.
// Holds the serializer FSM state type, the default word width and
// bit-period constants (also used by the detector testbench), and a
// helper that sizes counters so that a count range of 1 still gets a
// one-bit register.
package seq_det_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int unsigned SEQ_WIDTH = 8;
    localparam int unsigned SEQ_DIV   = 1;

    // Register width needed to count 0..n-1; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding register in front of the serializer shifter.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   load        - capture d and mark the entry full
//   clear       - mark the entry empty (the shifter took the word)
//   d           - incoming word
//   q           - held word
//   full        - entry occupied
// load and clear never coincide in use; load wins if they do.
module ser_hold_reg
    import seq_det_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= '0;
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end feeding the 1011 sequence detector.
// Words arrive over a valid/ready handshake into a one-entry holding
// register and are shifted out one bit per DIV clocks. A held word is
// loaded on the same edge the previous word's last bit expires, so
// consecutive words form a gap-free stream. Between words ser_out sits
// at IDLE_BIT.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   s_data      - word to serialize
//   s_valid     - s_data is valid
//   s_ready     - holding register empty, a word can be accepted
//   ser_out     - serial bit (registered), drives the detector input
//   ser_valid   - ser_out carries a data bit (registered)
//   word_start  - one-cycle pulse while bit 0 of a word is first shown
//   busy        - shifter active or holding register occupied
module seq_bit_serializer
    import seq_det_pkg::*;
#(
    parameter int unsigned WIDTH     = SEQ_WIDTH,
    parameter int unsigned DIV       = SEQ_DIV,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int unsigned BW = cnt_width(WIDTH);
    localparam int unsigned DW = cnt_width(DIV);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);

    ser_state_t       state, state_n;
    logic [WIDTH-1:0] sh_data, sh_n;
    logic [BW-1:0]    bit_idx, bit_n;
    logic [DW-1:0]    div_cnt, div_n;
    logic             reload;
    logic             ser_out_n;

    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             accept;

    assign s_ready = !hold_full;
    assign accept  = s_valid && s_ready;
    assign busy    = (state == SHIFT) || hold_full;

    ser_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .clear (reload),
        .d     (s_data),
        .q     (hold_data),
        .full  (hold_full)
    );

    always_comb begin
        state_n = state;
        sh_n    = sh_data;
        bit_n   = bit_idx;
        div_n   = div_cnt;
        reload  = 1'b0;

        case (state)
            IDLE: begin
                if (hold_full) begin
                    reload  = 1'b1;
                    state_n = SHIFT;
                    sh_n    = hold_data;
                    bit_n   = '0;
                    div_n   = '0;
                end
            end
            SHIFT: begin
                if (div_cnt == LAST_DIV) begin
                    div_n = '0;
                    if (bit_idx == LAST_BIT) begin
                        bit_n = '0;
                        if (hold_full) begin
                            // Next word takes over on this edge: no idle gap.
                            reload = 1'b1;
                            sh_n   = hold_data;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_n = bit_idx + BW'(1);
                        if (MSB_FIRST)
                            sh_n = {sh_data[WIDTH-2:0], 1'b0};
                        else
                            sh_n = {1'b0, sh_data[WIDTH-1:1]};
                    end
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from next-state values.
        if (state_n == SHIFT)
            ser_out_n = MSB_FIRST ? sh_n[WIDTH-1] : sh_n[0];
        else
            ser_out_n = IDLE_BIT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sh_data    <= '0;
            bit_idx    <= '0;
            div_cnt    <= '0;
            ser_out    <= IDLE_BIT;
            ser_valid  <= 1'b0;
            word_start <= 1'b0;
        end else begin
            state      <= state_n;
            sh_data    <= sh_n;
            bit_idx    <= bit_n;
            div_cnt    <= div_n;
            ser_out    <= ser_out_n;
            ser_valid  <= (state_n == SHIFT);
            word_start <= reload;
        end
    end

    // Upstream handshake rules: a stalled word stays put until taken.
    a_data_stable: assert property (@(posedge clk) disable iff (!reset)
        (s_valid && !s_ready) |=> $stable(s_data));

    a_valid_held: assert property (@(posedge clk) disable iff (!reset)
        (s_valid && !s_ready) |=> s_valid);

endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Parallel-to-serial front end that sits directly upstream of the 1011 sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per bit-period on `ser_out`, which drives the detector's `in`. A one-entry holding register keeps back-to-back words as a gap-free bit stream. Between words the line is driven with a fixed idle level so the detector sees no spurious pattern.

## Interface
- WIDTH, 8: word width in bits; legal range is 2 or more.
- DIV, 1: clock cycles per bit; legal range is 1 or more.
- MSB_FIRST, 1: 1 shifts MSB first, 0 shifts LSB first.
- IDLE_BIT, 0: level driven on `ser_out` when no word is being shifted.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low.
- s_data  input  WIDTH  word to serialize.
- s_valid  input  1  `s_data` is valid.
- s_ready  output  1  holding register is empty and can accept a word.
- ser_out  output  1  serial bit; connects to the detector's `in`.
- ser_valid  output  1  `ser_out` carries a data bit, not idle.
- word_start  output  1  high for the single cycle in which bit 0 of a word is first presented.
- busy  output  1  shifter active or holding register full.

## Operation
- Storage elements:
  - holding register `hold_data` with flag `hold_full`;
  - shifter `sh_data`;
  - bit index `bit_idx` (0..WIDTH-1);
  - divider count `div_cnt` (0..DIV-1);
  - FSM state.
- `s_ready = !hold_full` (combinational). A word is accepted when `s_valid && s_ready`: it is written to the holding register and `hold_full` sets.
- FSM states:
  - IDLE: `ser_out = IDLE_BIT`, `ser_valid = 0`. If `hold_full`, the next edge loads the shifter from hold, clears `hold_full`, sets `bit_idx = 0` and `div_cnt = 0`, and moves to SHIFT.
  - SHIFT: `ser_out` presents the current bit (MSB or LSB end of `sh_data`); `ser_valid = 1`. `div_cnt` increments each cycle.
    - At `div_cnt == DIV-1`: `div_cnt` goes to 0, the shifter shifts, and `bit_idx` increments.
    - At the last bit (`bit_idx == WIDTH-1`) with `div_cnt == DIV-1`: if `hold_full`, reload from hold in the same edge (stays in SHIFT, no gap); otherwise go to IDLE.
- `ser_out`, `ser_valid` and `word_start` are registered outputs.
- Accept and reload on the same edge cannot happen: the reload clears `hold_full`, so `s_ready` was low on that edge.
- Handshake rules, checked by assertion:
  - `s_data` must stay stable while `s_valid && !s_ready`.
  - `s_valid` must not drop before acceptance.
- Reset mid-word: the word in the shifter and the held word are both discarded. No partial word resumes.

## Timing
- Reset values:
  - FSM state = IDLE;
  - `ser_out = IDLE_BIT`;
  - `ser_valid = 0`;
  - `word_start = 0`;
  - `busy = 0`;
  - `hold_full = 0`, so `s_ready = 1`;
  - `bit_idx = 0`, `div_cnt = 0`.
- Latency, idle case: word accepted at edge k, shifter loaded at edge k+1. Bit 0 is presented from edge k+1 and held for DIV cycles. `word_start = 1` for the cycle after edge k+1.
- Word duration is WIDTH×DIV cycles. Back-to-back words give a continuous stream with zero idle cycles between the last bit of one word and bit 0 of the next.
- Throughput: one word per WIDTH×DIV cycles. `s_ready` reasserts the cycle after each reload.
- `busy` falls in the same cycle that `ser_valid` falls.

## Structure
- Shared package `seq_det_pkg` holds:
  - FSM state enum {IDLE, SHIFT};
  - default WIDTH and DIV constants, shared with the detector testbench.
- One natural sub-module: `ser_hold_reg`, the one-entry holding register with valid/ready (data, full flag, load/clear). The top level contains the FSM, shifter and counters.
- Top-level RTL is roughly 150–250 lines.

## Test plan
- Single word 8'hB0, DIV=1, MSB_FIRST=1, accept at edge k: `ser_out` is 1,0,1,1,0,0,0,0 after edges k+1..k+8, then IDLE_BIT. `word_start` is high one cycle. The downstream detector flags exactly one 1011 match.
- Back-to-back 8'h0B then 8'hB0 with `s_valid` held high: 16 contiguous bits with `ser_valid` high throughout and `word_start` pulsing at bits 0 and 8. `s_ready` low while hold is full.
- DIV=3, word 8'hA5: each bit held exactly 3 cycles; the word lasts 24 cycles; `busy` drops exactly 24 cycles after the load edge.
- Backpressure: present three words while the shifter is busy. The third stalls with `s_ready = 0`. `s_data` is held stable and is accepted on the cycle after the reload edge. No word is lost or duplicated.
- Reset asserted mid-word (after bit 3): `ser_out = IDLE_BIT`, `ser_valid = 0` and `s_ready = 1` immediately (asynchronous). After release, a new word 8'h0F shifts out cleanly from bit 0.
- MSB_FIRST=0, word 8'h0D: the output order is 1,0,1,1,0,0,0,0, LSB first.
